// File: rtl/cascade_count_ctrl.sv
// Two-digit cascaded mod-MOD counter controller with start/stop/hold/clear and a target stop.
// Optional AUTO_RELOAD_EN: a target hit reloads the counters to 0,0 and keeps running.
module cascade_count_ctrl #(
    parameter int MOD = 11,
    parameter int DW  = 4
) (
    input  logic          clk,
    input  logic          a_reset,
    input  logic          tick,
    input  logic          start,
    input  logic          stop,
    input  logic          clear,
    input  logic          tgt_load,
    input  logic [DW-1:0] target_ones,
    input  logic [DW-1:0] target_tens,
    output logic [DW-1:0] ones,
    output logic [DW-1:0] tens,
    output logic [1:0]    state,
    output logic          busy,
    output logic          done,
    output logic          done_pulse
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_HOLD = 2'b10,
        S_DONE = 2'b11
    } state_t;

    localparam logic [DW-1:0] MAXV = DW'(MOD - 1);
    localparam logic [DW:0]   MODW = (DW + 1)'(MOD);

    state_t        r_state, w_state_nxt;
    logic [DW-1:0] r_ones, r_tens, w_ones_nxt, w_tens_nxt;
    logic [DW-1:0] r_tgt_ones, r_tgt_tens, w_tgt_ones_nxt, w_tgt_tens_nxt;
    logic          r_done_pulse, w_pulse_nxt;
    logic          w_ones_en, w_tens_en, w_hit;
    logic [DW-1:0] w_ones_inc, w_tens_inc;

    // Compare one bit wider so MOD == 2^DW never overflows the clamp test.
    function automatic logic [DW-1:0] clamp_digit(input logic [DW-1:0] v);
        return ({1'b0, v} >= MODW) ? MAXV : v;
    endfunction

    // A tick only counts in RUN when no higher-priority command is present.
    assign w_ones_en  = tick & (r_state == S_RUN) & ~stop & ~clear;
    assign w_tens_en  = w_ones_en & (r_ones == MAXV);
    assign w_ones_inc = (r_ones == MAXV) ? '0 : r_ones + DW'(1);
    assign w_tens_inc = w_tens_en ? ((r_tens == MAXV) ? '0 : r_tens + DW'(1)) : r_tens;
    assign w_hit      = w_ones_en && (w_ones_inc == r_tgt_ones) && (w_tens_inc == r_tgt_tens);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt    = r_state;
        w_ones_nxt     = r_ones;
        w_tens_nxt     = r_tens;
        w_tgt_ones_nxt = r_tgt_ones;
        w_tgt_tens_nxt = r_tgt_tens;
        w_pulse_nxt    = 1'b0;
        if (clear) begin
            w_state_nxt = S_IDLE;
            w_ones_nxt  = '0;
            w_tens_nxt  = '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (tgt_load) begin
                        w_tgt_ones_nxt = clamp_digit(target_ones);
                        w_tgt_tens_nxt = clamp_digit(target_tens);
                    end
                    if (start && !stop) w_state_nxt = S_RUN;
                end
                S_RUN: begin
                    if (stop) begin
                        w_state_nxt = S_HOLD;
                    end else if (w_ones_en) begin
                        w_ones_nxt = w_ones_inc;
                        w_tens_nxt = w_tens_inc;
                        if (w_hit) begin
                            w_pulse_nxt = 1'b1;
`ifdef AUTO_RELOAD_EN
                            w_ones_nxt  = '0;
                            w_tens_nxt  = '0;
`else
                            w_state_nxt = S_DONE;
`endif
                        end
                    end
                end
                S_HOLD: begin
                    if (start && !stop) w_state_nxt = S_RUN;
                end
                S_DONE: begin
                    w_state_nxt = S_DONE;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge a_reset) begin
        if (a_reset) begin
            r_state      <= S_IDLE;
            r_ones       <= '0;
            r_tens       <= '0;
            r_tgt_ones   <= MAXV;
            r_tgt_tens   <= MAXV;
            r_done_pulse <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_ones       <= w_ones_nxt;
            r_tens       <= w_tens_nxt;
            r_tgt_ones   <= w_tgt_ones_nxt;
            r_tgt_tens   <= w_tgt_tens_nxt;
            r_done_pulse <= w_pulse_nxt;
        end
    end

    assign ones       = r_ones;
    assign tens       = r_tens;
    assign state      = r_state;
    assign busy       = (r_state == S_RUN) || (r_state == S_HOLD);
    assign done       = (r_state == S_DONE);
    assign done_pulse = r_done_pulse;

endmodule

// File: tb/tb_cascade_count_ctrl.sv
// Directed self-checking bench for cascade_count_ctrl (MOD=11, DW=4).
// Build with +define+AUTO_RELOAD_EN to check the auto-reload variant.
module tb_cascade_count_ctrl;

    logic       clk;
    logic       a_reset;
    logic       tick, start, stop, clear, tgt_load;
    logic [3:0] target_ones, target_tens;
    logic [3:0] ones, tens;
    logic [1:0] state;
    logic       busy, done, done_pulse;

    int n_cmp = 0;
    int n_err = 0;

    cascade_count_ctrl #(.MOD(11), .DW(4)) dut (
        .clk         (clk),
        .a_reset     (a_reset),
        .tick        (tick),
        .start       (start),
        .stop        (stop),
        .clear       (clear),
        .tgt_load    (tgt_load),
        .target_ones (target_ones),
        .target_tens (target_tens),
        .ones        (ones),
        .tens        (tens),
        .state       (state),
        .busy        (busy),
        .done        (done),
        .done_pulse  (done_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Checks tens, ones, state, done and done_pulse together.
    task automatic check_all(input string tag, input logic [3:0] t, input logic [3:0] o,
                             input logic [1:0] s, input logic d, input logic p);
        check({tag, ".tens"},  {4'b0, tens},       {4'b0, t});
        check({tag, ".ones"},  {4'b0, ones},       {4'b0, o});
        check({tag, ".state"}, {6'b0, state},      {6'b0, s});
        check({tag, ".done"},  {7'b0, done},       {7'b0, d});
        check({tag, ".pulse"}, {7'b0, done_pulse}, {7'b0, p});
    endtask

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        a_reset = 1'b1;
        {tick, start, stop, clear, tgt_load} = '0;
        target_ones = '0;
        target_tens = '0;
        #2;
        check_all("reset", 4'd0, 4'd0, 2'b00, 1'b0, 1'b0);
        check("reset.busy", {7'b0, busy}, 8'd0);
        #10 a_reset = 1'b0;
        cyc();

        // Async reset in the middle of RUN
        start = 1'b1; cyc(); start = 1'b0;
        check("run.busy", {7'b0, busy}, 8'd1);
        tick = 1'b1; repeat (5) cyc(); tick = 1'b0;
        check_all("pre_rst", 4'd0, 4'd5, 2'b01, 1'b0, 1'b0);
        #2 a_reset = 1'b1;
        #1;
        check_all("mid_rst", 4'd0, 4'd0, 2'b00, 1'b0, 1'b0);
        #1 a_reset = 1'b0;
        cyc();

        // Ones wrap carries into tens on the 11th tick
        start = 1'b1; cyc(); start = 1'b0;
        tick = 1'b1; repeat (10) cyc();
        check_all("wrap10", 4'd0, 4'd10, 2'b01, 1'b0, 1'b0);
        cyc(); tick = 1'b0;
        check_all("wrap11", 4'd1, 4'd0, 2'b01, 1'b0, 1'b0);
        clear = 1'b1; cyc(); clear = 1'b0;
        check_all("clr1", 4'd0, 4'd0, 2'b00, 1'b0, 1'b0);

        // Target (tens=1, ones=2) reached on the 13th tick
        target_tens = 4'd1; target_ones = 4'd2; tgt_load = 1'b1; cyc(); tgt_load = 1'b0;
        start = 1'b1; cyc(); start = 1'b0;
        tick = 1'b1; repeat (12) cyc();
        check_all("tgt12", 4'd1, 4'd1, 2'b01, 1'b0, 1'b0);
        cyc();
`ifdef AUTO_RELOAD_EN
        check_all("tgt13", 4'd0, 4'd0, 2'b01, 1'b0, 1'b1);
        cyc();
        check_all("tgt14", 4'd0, 4'd1, 2'b01, 1'b0, 1'b0);
        tick = 1'b0;
`else
        check_all("tgt13", 4'd1, 4'd2, 2'b11, 1'b1, 1'b1);
        check("done.busy", {7'b0, busy}, 8'd0);
        cyc();
        check_all("tgt14", 4'd1, 4'd2, 2'b11, 1'b1, 1'b0);
        tick = 1'b0; start = 1'b1; stop = 1'b1; cyc(); start = 1'b0; stop = 1'b0;
        check_all("done_ign", 4'd1, 4'd2, 2'b11, 1'b1, 1'b0);
`endif
        clear = 1'b1; cyc(); clear = 1'b0;
        check_all("clr2", 4'd0, 4'd0, 2'b00, 1'b0, 1'b0);

        // Pause: stop with tick wins, HOLD freezes, start resumes
        start = 1'b1; cyc(); start = 1'b0;
        tick = 1'b1; repeat (4) cyc();
        stop = 1'b1; cyc(); stop = 1'b0;
        check_all("hold", 4'd0, 4'd4, 2'b10, 1'b0, 1'b0);
        repeat (3) cyc();
        check_all("hold3", 4'd0, 4'd4, 2'b10, 1'b0, 1'b0);
        check("hold.busy", {7'b0, busy}, 8'd1);
        tick = 1'b0; stop = 1'b1; cyc(); stop = 1'b0;
        check("hold_stop", {6'b0, state}, 8'd2);
        start = 1'b1; cyc(); start = 1'b0;
        check_all("resume", 4'd0, 4'd4, 2'b01, 1'b0, 1'b0);
        tick = 1'b1; cyc(); tick = 1'b0;
        check_all("resume1", 4'd0, 4'd5, 2'b01, 1'b0, 1'b0);

        // Clamp ones=12 -> 10; load during RUN ignored
        clear = 1'b1; cyc(); clear = 1'b0;
        target_tens = 4'd0; target_ones = 4'd12; tgt_load = 1'b1; cyc(); tgt_load = 1'b0;
        start = 1'b1; cyc(); start = 1'b0;
        target_ones = 4'd3; tgt_load = 1'b1; tick = 1'b1; cyc(); tgt_load = 1'b0;
        repeat (8) cyc();
        check_all("clamp9", 4'd0, 4'd9, 2'b01, 1'b0, 1'b0);
        cyc(); tick = 1'b0;
`ifdef AUTO_RELOAD_EN
        check_all("clamp10", 4'd0, 4'd0, 2'b01, 1'b0, 1'b1);
`else
        check_all("clamp10", 4'd0, 4'd10, 2'b11, 1'b1, 1'b1);
`endif
        start = 1'b1; stop = 1'b1; clear = 1'b1; cyc();
        {start, stop, clear} = '0;
        check_all("all_cmd", 4'd0, 4'd0, 2'b00, 1'b0, 1'b0);

        // Load and start in one IDLE cycle, target (0,3)
        target_tens = 4'd0; target_ones = 4'd3; tgt_load = 1'b1; start = 1'b1; cyc();
        tgt_load = 1'b0; start = 1'b0;
        check("ld_start", {6'b0, state}, 8'd1);
        tick = 1'b1;
`ifdef AUTO_RELOAD_EN
        for (int i = 1; i <= 7; i++) begin
            cyc();
            check($sformatf("ar_pulse%0d", i), {7'b0, done_pulse}, {7'b0, (i == 3 || i == 6)});
        end
        tick = 1'b0;
        check_all("ar7", 4'd0, 4'd1, 2'b01, 1'b0, 1'b0);
`else
        repeat (2) cyc();
        check_all("t03_2", 4'd0, 4'd2, 2'b01, 1'b0, 1'b0);
        cyc(); tick = 1'b0;
        check_all("t03_3", 4'd0, 4'd3, 2'b11, 1'b1, 1'b1);
`endif
        clear = 1'b1; cyc(); clear = 1'b0;

        // Target (0,0) needs a full 121-tick wrap
        target_ones = 4'd0; tgt_load = 1'b1; start = 1'b1; cyc();
        tgt_load = 1'b0; start = 1'b0;
        tick = 1'b1; repeat (120) cyc();
        check_all("t00_120", 4'd10, 4'd10, 2'b01, 1'b0, 1'b0);
        cyc(); tick = 1'b0;
`ifdef AUTO_RELOAD_EN
        check_all("t00_121", 4'd0, 4'd0, 2'b01, 1'b0, 1'b1);
`else
        check_all("t00_121", 4'd0, 4'd0, 2'b11, 1'b1, 1'b1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
